// File: rtl/bank_group_pkg.sv
// Shared types and helpers for the bank group command FSM.
package bank_group_pkg;

  typedef enum logic [2:0] {
    CmdNop  = 3'd0,
    CmdAct  = 3'd1,
    CmdRd   = 3'd2,
    CmdWr   = 3'd3,
    CmdPre  = 3'd4,
    CmdPrea = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    StIdle,
    StActivating,
    StActive,
    StPrecharging
  } bank_state_e;

  function automatic int unsigned timer_width(int unsigned trcd, int unsigned trp);
    int unsigned mx;
    mx = (trcd > trp) ? trcd : trp;
    return unsigned'($clog2(mx + 1));
  endfunction

endpackage

// File: rtl/bank_fsm.sv
// Single-bank state machine: tracks IDLE/ACTIVATING/ACTIVE/PRECHARGING, the open row
// and the tRCD/tRP countdown. act/pre are only asserted by the parent when legal.
module bank_fsm
  import bank_group_pkg::*;
#(
  parameter int unsigned ROWWIDTH = 5,
  parameter int unsigned TRCD     = 4,
  parameter int unsigned TRP      = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                act,
  input  logic                pre,
  input  logic [ROWWIDTH-1:0] act_row,
  output bank_state_e         state,
  output logic [ROWWIDTH-1:0] row
);

  localparam int unsigned TW = timer_width(TRCD, TRP);

  logic [TW-1:0] timer;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= StIdle;
      timer <= '0;
      row   <= '0;
    end else begin
      if (timer != '0) timer <= timer - TW'(1);
      unique case (state)
        StIdle: begin
          if (act) begin
            row <= act_row;
            // A one-cycle delay skips the transient state entirely.
            if (TRCD > 1) begin
              state <= StActivating;
              timer <= TW'(TRCD - 1);
            end else begin
              state <= StActive;
            end
          end
        end
        StActivating: begin
          if (timer <= TW'(1)) state <= StActive;
        end
        StActive: begin
          if (pre) begin
            if (TRP > 1) begin
              state <= StPrecharging;
              timer <= TW'(TRP - 1);
            end else begin
              state <= StIdle;
            end
          end
        end
        StPrecharging: begin
          if (timer <= TW'(1)) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/bank_group_fsm.sv
// Bank group front end: decodes one command per cycle, checks it against per-bank state,
// drives registered strobes/column to the bank arrays and times read-data-valid.
module bank_group_fsm
  import bank_group_pkg::*;
#(
  parameter int unsigned BAWIDTH  = 2,
  parameter int unsigned ROWWIDTH = 5,
  parameter int unsigned COLWIDTH = 10,
  parameter int unsigned TRCD     = 4,
  parameter int unsigned TRP      = 4,
  parameter int unsigned CL       = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           cmd_valid,
  input  logic [2:0]                     cmd,
  input  logic [BAWIDTH-1:0]             cmd_ba,
  input  logic [ROWWIDTH-1:0]            cmd_row,
  input  logic [COLWIDTH-1:0]            cmd_col,
  output logic [(2**BAWIDTH)*ROWWIDTH-1:0] bank_row,
  output logic [COLWIDTH-1:0]            bank_col,
  output logic [(2**BAWIDTH)-1:0]        bank_rd,
  output logic [(2**BAWIDTH)-1:0]        bank_wr,
  output logic [(2**BAWIDTH)-1:0]        bank_open,
  output logic                           rd_valid,
  output logic [BAWIDTH-1:0]             rd_ba,
  output logic                           cmd_err
);

  localparam int unsigned NBANKS = 2 ** BAWIDTH;

  bank_state_e       st [NBANKS];
  logic [NBANKS-1:0] act_v;
  logic [NBANKS-1:0] pre_v;
  logic [NBANKS-1:0] ba_onehot;
  logic              legal;
  logic              is_rd;
  logic              is_wr;
  logic              any_busy;

  logic [CL-1:0]      rdv_q;
  logic [BAWIDTH-1:0] rba_q [CL];

  assign ba_onehot = NBANKS'(1) << cmd_ba;

  for (genvar i = 0; i < NBANKS; i++) begin : g_bank
    bank_fsm #(
      .ROWWIDTH (ROWWIDTH),
      .TRCD     (TRCD),
      .TRP      (TRP)
    ) u_bank (
      .clk     (clk),
      .rstn    (rstn),
      .act     (act_v[i]),
      .pre     (pre_v[i]),
      .act_row (cmd_row),
      .state   (st[i]),
      .row     (bank_row[i*ROWWIDTH +: ROWWIDTH])
    );
    assign bank_open[i] = (st[i] == StActive);
  end

  always_comb begin
    act_v    = '0;
    pre_v    = '0;
    legal    = 1'b1;
    is_rd    = 1'b0;
    is_wr    = 1'b0;
    any_busy = 1'b0;
    for (int unsigned i = 0; i < NBANKS; i++) begin
      if (st[i] == StActivating || st[i] == StPrecharging) any_busy = 1'b1;
    end
    if (cmd_valid) begin
      case (cmd_e'(cmd))
        CmdNop: legal = 1'b1;
        CmdAct: begin
          if (st[cmd_ba] == StIdle) act_v[cmd_ba] = 1'b1;
          else legal = 1'b0;
        end
        CmdRd: begin
          if (st[cmd_ba] == StActive) is_rd = 1'b1;
          else legal = 1'b0;
        end
        CmdWr: begin
          if (st[cmd_ba] == StActive) is_wr = 1'b1;
          else legal = 1'b0;
        end
        CmdPre: begin
          // PRE to an idle bank is accepted as a no-op.
          if (st[cmd_ba] == StActive) pre_v[cmd_ba] = 1'b1;
          else if (st[cmd_ba] != StIdle) legal = 1'b0;
        end
        CmdPrea: begin
          if (any_busy) begin
            legal = 1'b0;
          end else begin
            for (int unsigned i = 0; i < NBANKS; i++) pre_v[i] = (st[i] == StActive);
          end
        end
        default: legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_col <= '0;
      bank_rd  <= '0;
      bank_wr  <= '0;
      cmd_err  <= 1'b0;
      rdv_q    <= '0;
      for (int unsigned i = 0; i < CL; i++) rba_q[i] <= '0;
    end else begin
      cmd_err <= ~legal;
      bank_rd <= is_rd ? ba_onehot : '0;
      bank_wr <= is_wr ? ba_onehot : '0;
      if (is_rd || is_wr) bank_col <= cmd_col;
      rdv_q[0] <= is_rd;
      rba_q[0] <= is_rd ? cmd_ba : '0;
      for (int unsigned i = 1; i < CL; i++) begin
        rdv_q[i] <= rdv_q[i-1];
        rba_q[i] <= rba_q[i-1];
      end
    end
  end

  assign rd_valid = rdv_q[CL-1];
  assign rd_ba    = rba_q[CL-1];

endmodule
